// File: rtl/nibble_packer_if.sv
// Handshake bundle for nibble_packer: nibble stream in, packed-word stream out.
// master = upstream/consumer side, slave = the packer itself.
interface nibble_packer_if #(
  parameter int NIBBLES = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [3:0]             in_nibble;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [4*NIBBLES-1:0]   out_data;
  logic [2:0]             out_count;
  logic                   out_last;

  modport master (
    output in_valid, in_nibble, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_last
  );

  modport slave (
    input  in_valid, in_nibble, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_last
  );
endinterface

// File: rtl/nibble_packer.sv
// Packs NIBBLES little-endian nibbles into a word; NIBBLE_PACK_TIMEOUT_EN adds an idle flush.
// Latency: word is valid one clock after its completing nibble (or flush) edge.
// Backpressure: in_ready = !out_valid || out_ready; a stalled word blocks all input.
module nibble_packer #(
  parameter int NIBBLES = 4
`ifdef NIBBLE_PACK_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  nibble_packer_if.slave   bus
);

  localparam int W = 4 * NIBBLES;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e         state_q;
  logic [W-1:0]   acc_q;
  logic [W-1:0]   acc_d;
  logic [2:0]     cnt_q;
  logic [W-1:0]   data_q;
  logic [2:0]     count_q;
  logic           last_q;

  logic           out_free;
  logic           accept;
  logic           complete;
  logic           flush;

  assign out_free = (state_q == FILL) || bus.out_ready;
  assign accept   = bus.in_valid && out_free;
  assign complete = accept && (bus.in_last || (cnt_q == 3'(NIBBLES - 1)));

  // Higher nibbles of acc_q are always zero, so the merged word is already zero-padded.
  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < NIBBLES; i++) begin
      if (cnt_q == 3'(i)) begin
        acc_d[4*i +: 4] = bus.in_nibble;
      end
    end
  end

`ifdef NIBBLE_PACK_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] timer_q;

  // Timer saturates at TIMEOUT-1 so a flush blocked by the output fires as soon as it frees.
  assign flush = !accept && (cnt_q != 3'd0) && (timer_q == TW'(TIMEOUT - 1)) && out_free;
`else
  assign flush = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      acc_q   <= '0;
      cnt_q   <= 3'd0;
      data_q  <= '0;
      count_q <= 3'd0;
      last_q  <= 1'b0;
`ifdef NIBBLE_PACK_TIMEOUT_EN
      timer_q <= '0;
`endif
    end else begin
      if (complete) begin
        data_q  <= acc_d;
        count_q <= cnt_q + 3'd1;
        last_q  <= bus.in_last;
        state_q <= HOLD;
        acc_q   <= '0;
        cnt_q   <= 3'd0;
      end else if (flush) begin
        data_q  <= acc_q;
        count_q <= cnt_q;
        last_q  <= 1'b1;
        state_q <= HOLD;
        acc_q   <= '0;
        cnt_q   <= 3'd0;
      end else begin
        if (accept) begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 3'd1;
        end
        if ((state_q == HOLD) && bus.out_ready) begin
          state_q <= FILL;
        end
      end
`ifdef NIBBLE_PACK_TIMEOUT_EN
      if (accept || flush || (cnt_q == 3'd0)) begin
        timer_q <= '0;
      end else if (timer_q != TW'(TIMEOUT - 1)) begin
        timer_q <= timer_q + 1'b1;
      end
`endif
    end
  end

  assign bus.in_ready  = out_free;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = data_q;
  assign bus.out_count = count_q;
  assign bus.out_last  = last_q;

endmodule

// File: tb/tb_nibble_packer.sv
// Directed self-checking bench for nibble_packer (NIBBLES = 4, TIMEOUT = 16 when enabled).
module tb_nibble_packer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  nibble_packer_if #(.NIBBLES(4)) bus_if ();

  nibble_packer #(.NIBBLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one nibble and waits (bounded) for the edge that accepts it.
  task automatic send(input logic [3:0] n, input logic l);
    bit ok;
    ok = 1'b0;
    bus_if.in_valid  = 1'b1;
    bus_if.in_nibble = n;
    bus_if.in_last   = l;
    for (int k = 0; k < 50 && !ok; k++) begin
      if (bus_if.in_ready) ok = 1'b1;
      tick();
    end
    bus_if.in_valid = 1'b0;
    bus_if.in_last  = 1'b0;
    check_eq("send_accepted", 32'(ok), 32'd1);
  endtask

  task automatic check_word(input string tag, input logic [15:0] d, input logic [2:0] c,
                            input logic l);
    check_eq({tag, "_valid"}, 32'(bus_if.out_valid), 32'd1);
    check_eq({tag, "_data"},  32'(bus_if.out_data),  32'(d));
    check_eq({tag, "_count"}, 32'(bus_if.out_count), 32'(c));
    check_eq({tag, "_last"},  32'(bus_if.out_last),  32'(l));
  endtask

  initial begin
    int waited;
    n_checks = 0;
    n_fail   = 0;
    rst               = 1'b1;
    bus_if.in_valid   = 1'b0;
    bus_if.in_nibble  = 4'h0;
    bus_if.in_last    = 1'b0;
    bus_if.out_ready  = 1'b1;

    // Post-reset idle
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_eq("rst_in_ready",  32'(bus_if.in_ready),  32'd1);
    check_eq("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check_eq("rst_out_data",  32'(bus_if.out_data),  32'h0000);
    check_eq("rst_out_count", 32'(bus_if.out_count), 32'd0);
    check_eq("rst_out_last",  32'(bus_if.out_last),  32'd0);

    // Basic pack, single-cycle pulse with out_ready high
    send(4'hA, 1'b0);
    send(4'hA, 1'b0);
    send(4'h0, 1'b0);
    check_eq("basic_not_yet", 32'(bus_if.out_valid), 32'd0);
    send(4'h0, 1'b0);
    check_word("basic", 16'h00AA, 3'd4, 1'b0);
    tick();
    check_eq("basic_pulse_end", 32'(bus_if.out_valid), 32'd0);

    // Early last, then the next word restarts at nibble 0
    send(4'h0, 1'b0);
    send(4'hF, 1'b1);
    check_word("early", 16'h00F0, 3'd2, 1'b1);
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    send(4'h4, 1'b0);
    check_word("after_early", 16'h4321, 3'd4, 1'b0);
    tick();

    // Single-nibble frame
    send(4'h9, 1'b1);
    check_word("one_nib", 16'h0009, 3'd1, 1'b1);
    tick();

    // Backpressure: stalled word holds, offered nibble is ignored
    bus_if.out_ready = 1'b0;
    send(4'hA, 1'b0);
    send(4'hA, 1'b0);
    send(4'h0, 1'b0);
    send(4'h0, 1'b0);
    check_word("bp_load", 16'h00AA, 3'd4, 1'b0);
    bus_if.in_valid  = 1'b1;
    bus_if.in_nibble = 4'h5;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_in_ready", 32'(bus_if.in_ready), 32'd0);
      tick();
      check_eq("bp_hold_valid", 32'(bus_if.out_valid), 32'd1);
      check_eq("bp_hold_data",  32'(bus_if.out_data),  32'h00AA);
    end
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    tick();
    check_eq("bp_release", 32'(bus_if.out_valid), 32'd0);

    // Throughput: continuous nibbles 0..B, a word every 4 accepts, nothing dropped
    for (int i = 0; i < 12; i++) begin
      bus_if.in_valid  = 1'b1;
      bus_if.in_nibble = 4'(i);
      check_eq("tp_in_ready", 32'(bus_if.in_ready), 32'd1);
      tick();
      if (i % 4 == 3) begin
        case (i)
          3:       check_word("tp_w0", 16'h3210, 3'd4, 1'b0);
          7:       check_word("tp_w1", 16'h7654, 3'd4, 1'b0);
          default: check_word("tp_w2", 16'hBA98, 3'd4, 1'b0);
        endcase
      end else begin
        check_eq("tp_gap", 32'(bus_if.out_valid), 32'd0);
      end
    end
    bus_if.in_valid = 1'b0;
    tick();

    // Reset mid-word discards the partial word
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_valid", 32'(bus_if.out_valid), 32'd0);
    send(4'h3, 1'b0);
    send(4'h4, 1'b0);
    send(4'h5, 1'b0);
    send(4'h6, 1'b0);
    check_word("mid_rst", 16'h6543, 3'd4, 1'b0);
    tick();

    // Idle partial word
    send(4'h7, 1'b0);
    waited = 0;
    for (int k = 1; k <= 40 && waited == 0; k++) begin
      tick();
      if (bus_if.out_valid) waited = k;
    end
`ifdef NIBBLE_PACK_TIMEOUT_EN
    check_eq("to_delay", 32'(waited), 32'd16);
    check_word("to_flush", 16'h0007, 3'd1, 1'b1);
    tick();
    check_eq("to_after", 32'(bus_if.out_valid), 32'd0);
`else
    check_eq("no_to_valid", 32'(waited), 32'd0);
    send(4'h8, 1'b1);
    check_word("no_to_resume", 16'h0087, 3'd2, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
